nbit_rr_mux: RTL and testbench



---
 rtl/nbit_rr_mux.sv | 89 ++++++++
 tb/tb_nbit_rr_mux.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/nbit_rr_mux.sv
// nbit_rr_mux: N-to-1 valid/ready mux, round-robin arbiter, registered out.
// Define NBIT_RR_MUX_FIXED_PRIORITY_EN for lowest-lane-wins arbitration.
module nbit_rr_mux #(
  parameter int SELECT_WIDTH = 3,
  parameter int DATA_WIDTH   = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic [(2**SELECT_WIDTH)*DATA_WIDTH-1:0] MuxIn,
  input  logic [(2**SELECT_WIDTH)-1:0] MuxValid,
  output logic [(2**SELECT_WIDTH)-1:0] MuxReady,
  output logic [DATA_WIDTH-1:0] MuxOut,
  output logic MuxOutValid,
  input  logic MuxOutReady,
  output logic [SELECT_WIDTH-1:0] MuxSel
);
  localparam int N = 2**SELECT_WIDTH;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t state, stateNext;
  logic loadEn, anyValid, xfer;
  logic [SELECT_WIDTH-1:0] base, idx, candIdx;
  logic [DATA_WIDTH-1:0] candWord;

`ifdef NBIT_RR_MUX_FIXED_PRIORITY_EN
  assign base = '0;
`else
  logic [SELECT_WIDTH-1:0] lastGrant;

  // Search starts just past the last accepted lane; wraps modulo N.
  assign base = lastGrant + SELECT_WIDTH'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lastGrant <= '1;
    else if (xfer) lastGrant <= candIdx;
  end
`endif

  assign MuxOutValid = (state == FULL);
  assign loadEn = !MuxOutValid || MuxOutReady;
  assign xfer = loadEn && anyValid && reset_n;

  always_comb begin
    anyValid = 1'b0;
    candIdx = '0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = base + SELECT_WIDTH'(k);
      if (!anyValid && MuxValid[idx]) begin
        anyValid = 1'b1;
        candIdx = idx;
      end
    end
  end

  always_comb begin
    candWord = '0;
    for (int i = 0; i < N; i++) begin
      if (candIdx == SELECT_WIDTH'(i))
        candWord = MuxIn[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    MuxReady = '0;
    if (xfer) MuxReady[candIdx] = 1'b1;
  end

  always_comb begin
    stateNext = state;
    if (loadEn) stateNext = anyValid ? FULL : EMPTY;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= EMPTY;
      MuxOut <= '0;
      MuxSel <= '0;
    end else begin
      state <= stateNext;
      if (xfer) begin
        MuxOut <= candWord;
        MuxSel <= candIdx;
      end
    end
  end

endmodule

// File: tb/tb_nbit_rr_mux.sv
// tb_nbit_rr_mux: scoreboard bench for nbit_rr_mux (4 lanes x 8 bits).
// Directed phases followed by randomized traffic with a mid-run reset.
module tb_nbit_rr_mux;
  localparam int SW = 2;
  localparam int DW = 8;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic [N*DW-1:0] muxIn;
  logic [N-1:0] muxValid, muxReady;
  logic [DW-1:0] muxOut;
  logic muxOutValid, muxOutReady;
  logic [SW-1:0] muxSel;

  int tests = 0;
  int fails = 0;
  int lastG;
  int grantLast;
  bit full;
  logic [DW-1:0] expWord[$];
  int expLane[$];

  always #5 clk = ~clk;

  nbit_rr_mux #(.SELECT_WIDTH(SW), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .MuxIn(muxIn),
    .MuxValid(muxValid),
    .MuxReady(muxReady),
    .MuxOut(muxOut),
    .MuxOutValid(muxOutValid),
    .MuxOutReady(muxOutReady),
    .MuxSel(muxSel)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbiter: first valid lane scanning up from lastG+1 mod N.
  function automatic int pick(logic [N-1:0] v);
    int i;
    for (int k = 0; k < N; k++) begin
`ifdef NBIT_RR_MUX_FIXED_PRIORITY_EN
      i = k;
`else
      i = (lastG + 1 + k) % N;
`endif
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic cycle(logic [N-1:0] v, logic [N*DW-1:0] d, logic r);
    int c;
    logic [N-1:0] expR;
    @(posedge clk);
    #1;
    check("outValid", 32'(muxOutValid), 32'(full));
    muxValid = v;
    muxIn = d;
    muxOutReady = r;
    #1;
    c = pick(v);
    expR = '0;
    grantLast = -1;
    if ((!full || r) && c >= 0) expR[c] = 1'b1;
    check("muxReady", 32'(muxReady), 32'(expR));
    if (expR != '0) begin
      expWord.push_back(d[c*DW +: DW]);
      expLane.push_back(c);
      lastG = c;
      grantLast = c;
    end
    if (!full || r) full = (c >= 0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    muxValid = 4'($urandom) | 4'b0001;
    #1;
    check("rstOutValid", 32'(muxOutValid), 0);
    check("rstOut", 32'(muxOut), 0);
    check("rstSel", 32'(muxSel), 0);
    check("rstReady", 32'(muxReady), 0);
    expWord.delete();
    expLane.delete();
    full = 1'b0;
    lastG = N - 1;
    grantLast = -1;
    muxValid = '0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && muxOutValid === 1'b1) begin
        if (expLane.size() == 0) begin
          check("spuriousOut", 1, 0);
        end else begin
          check("muxSel", 32'(muxSel), 32'(expLane[0]));
          check("muxOut", 32'(muxOut), 32'(expWord[0]));
          if (muxOutReady) begin
            void'(expLane.pop_front());
            void'(expWord.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [N-1:0] v;
    logic [N*DW-1:0] d;
    reset_n = 1'b0;
    muxValid = 4'($urandom) | 4'b0001;
    muxIn = 32'h13121110;
    muxOutReady = 1'b1;
    full = 1'b0;
    lastG = N - 1;
    grantLast = -1;
    #1;
    check("initOutValid", 32'(muxOutValid), 0);
    check("initOut", 32'(muxOut), 0);
    check("initSel", 32'(muxSel), 0);
    check("initReady", 32'(muxReady), 0);
    muxValid = '0;
    #11;
    reset_n = 1'b1;

    cycle(4'b0100, 32'h00A50000, 1'b1);
    cycle(4'b0000, 32'h00A50000, 1'b1);
    cycle(4'b0000, 32'h00A50000, 1'b1);

    for (int i = 0; i < 8; i++) cycle(4'hF, 32'h13121110, 1'b1);
    cycle(4'b0000, 32'h13121110, 1'b1);

    cycle(4'b0010, 32'h13121110, 1'b1);
    for (int i = 0; i < 3; i++) cycle(4'b1100, 32'h13121110, 1'b0);
    cycle(4'b1100, 32'h13121110, 1'b1);
    cycle(4'b1000, 32'h13121110, 1'b1);
    cycle(4'b0000, 32'h13121110, 1'b1);
    cycle(4'b0000, 32'h13121110, 1'b1);

    for (int i = 0; i < 3; i++) cycle(4'hF, 32'h13121110, 1'b1);
    doReset();
    for (int i = 0; i < 4; i++) cycle(4'hF, 32'h13121110, 1'b1);

    v = '0;
    d = '0;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!(v[i] && grantLast != i && $urandom_range(0, 3) != 0)) begin
          v[i] = 1'($urandom_range(0, 1));
          d[i*DW +: DW] = 8'($urandom);
        end
      end
      cycle(v, d, 1'($urandom_range(0, 3) != 0));
      if (t == 200) begin
        doReset();
        v = '0;
      end
    end

    for (int i = 0; i < 3; i++) cycle(4'b0000, d, 1'b1);
    check("drained", 32'(expLane.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
